// File: rtl/timer_pkg.sv
// Shared constants for the playback-position timer: position limit and
// active-low 7-segment patterns (bit0 = a ... bit6 = g).
package timer_pkg;

    localparam logic [9:0] MAX_SECONDS = 10'd599;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Non-decimal codes blank the digit rather than showing garbage.
    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_timer.sv
// Purely combinational M:SS display driver: three identical BCD to
// active-low 7-segment decoders.
module display_timer
    import timer_pkg::*;
(
    input  logic [3:0] seconds0,
    input  logic [3:0] seconds1,
    input  logic [3:0] minutes0,
    output logic [6:0] seconds_lsd,
    output logic [6:0] seconds_msd,
    output logic [6:0] minutes
);

    always_comb begin
        seconds_lsd = seg_encode(seconds0);
        seconds_msd = seg_encode(seconds1);
        minutes     = seg_encode(minutes0);
    end

endmodule

// File: rtl/timer.sv
// Playback-position timer: seconds register 0..599 stepped by a signed,
// saturating increment, split into BCD M:SS and decoded for 7-segment display.
module timer
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       count,
    input  logic [8:0] adder,
    output logic [3:0] seconds0,
    output logic [3:0] seconds1,
    output logic [3:0] minutes0,
    output logic [6:0] seconds_lsd,
    output logic [6:0] seconds_msd,
    output logic [6:0] minutes
);

    localparam logic signed [11:0] MAX_SUM = $signed({2'b00, MAX_SECONDS});

    logic [9:0]        total_q;
    logic [9:0]        total_d;
    logic signed [11:0] sum_w;
    logic [3:0]        min_w;
    logic [5:0]        sec_w;

    // 12-bit signed sum covers -256..854, so clamping sees the true result.
    always_comb begin
        sum_w   = $signed({2'b00, total_q}) + $signed({{3{adder[8]}}, adder});
        total_d = total_q;
        if (count) begin
            if (sum_w < 12'sd0) begin
                total_d = '0;
            end else if (sum_w > MAX_SUM) begin
                total_d = MAX_SECONDS;
            end else begin
                total_d = sum_w[9:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its inputs; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    always_comb begin
        min_w    = 4'(total_q / 10'd60);
        sec_w    = 6'(total_q - 10'(min_w) * 10'd60);
        minutes0 = min_w;
        seconds1 = 4'(sec_w / 6'd10);
        seconds0 = 4'(sec_w % 6'd10);
    end

    display_timer u_display (
        .seconds0    (seconds0),
        .seconds1    (seconds1),
        .minutes0    (minutes0),
        .seconds_lsd (seconds_lsd),
        .seconds_msd (seconds_msd),
        .minutes     (minutes)
    );

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer: stimulus pushes hand-computed M:SS expectations,
// a negedge monitor pops them and compares BCD and segment outputs.
module tb_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       count;
    logic [8:0] adder;
    logic [3:0] seconds0, seconds1, minutes0;
    logic [6:0] seconds_lsd, seconds_msd, minutes;

    typedef struct {
        string      name;
        logic [3:0] m;
        logic [3:0] s1;
        logic [3:0] s0;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    timer dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .adder       (adder),
        .seconds0    (seconds0),
        .seconds1    (seconds1),
        .minutes0    (minutes0),
        .seconds_lsd (seconds_lsd),
        .seconds_msd (seconds_msd),
        .minutes     (minutes)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_bcd"}, {9'd0, minutes0, seconds1, seconds0},
                  {9'd0, e.m, e.s1, e.s0});
            check({e.name, "_seg"}, {minutes, seconds_msd, seconds_lsd},
                  {seg_tab[e.m], seg_tab[e.s1], seg_tab[e.s0]});
        end
    end

    // Apply inputs for n rising edges, then queue the expected position.
    task automatic step(input string name, input logic r, input logic c, input int a,
                        input int n, input int m, input int s1, input int s0);
        exp_t e;
        reset = r;
        count = c;
        adder = 9'(a);
        repeat (n) @(posedge clk);
        e.name = name;
        e.m    = 4'(m);
        e.s1   = 4'(s1);
        e.s0   = 4'(s0);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        count = 1'b0;
        adder = '0;
        @(negedge clk);

        step("reset",        1, 0,    0,   1, 0, 0, 0);
        step("run_0_59",     0, 1,    1,  59, 0, 5, 9);
        step("run_1_00",     0, 1,    1,   1, 1, 0, 0);
        step("run_1_40",     0, 1,    1,  40, 1, 4, 0);
        step("pause",        0, 0,    1, 100, 1, 4, 0);
        step("resume_2_10",  0, 1,    1,  30, 2, 1, 0);
        step("reset_mid",    1, 1,    1,   1, 0, 0, 0);
        step("after_reset",  0, 1,    1,   1, 0, 0, 1);

        step("clr_a",        1, 0,    0,   1, 0, 0, 0);
        step("step8_0_56",   0, 1,    8,   7, 0, 5, 6);
        step("step8_1_04",   0, 1,    8,   1, 1, 0, 4);
        step("step15_2_04",  0, 1,   15,   4, 2, 0, 4);

        step("clr_b",        1, 0,    0,   1, 0, 0, 0);
        step("to_0_25",      0, 1,   25,   1, 0, 2, 5);
        step("neg10_0_15",   0, 1,  -10,   1, 0, 1, 5);
        step("neg10_0_05",   0, 1,  -10,   1, 0, 0, 5);
        step("neg10_floor",  0, 1,  -10,   1, 0, 0, 0);
        step("neg30_floor",  0, 1,  -30,   1, 0, 0, 0);

        step("to_1_00",      0, 1,   60,   1, 1, 0, 0);
        step("neg1_0_59",    0, 1,   -1,   1, 0, 5, 9);
        step("zero_step",    0, 1,    0,   3, 0, 5, 9);

        step("clr_c",        1, 0,    0,   1, 0, 0, 0);
        step("to_8_30",      0, 1,  255,   2, 8, 3, 0);
        step("to_9_55",      0, 1,   85,   1, 9, 5, 5);
        step("ceil_9_59",    0, 1,    8,   1, 9, 5, 9);
        step("ceil_hold",    0, 1,    8,   2, 9, 5, 9);

        step("clr_d",        1, 0,    0,   1, 0, 0, 0);
        step("to_4_15",      0, 1,  255,   1, 4, 1, 5);
        step("to_5_00",      0, 1,   45,   1, 5, 0, 0);
        step("to_9_15",      0, 1,  255,   1, 9, 1, 5);
        step("ceil_255",     0, 1,  255,   1, 9, 5, 9);
        step("neg256_5_43",  0, 1, -256,   1, 5, 4, 3);
        step("neg256_1_27",  0, 1, -256,   1, 1, 2, 7);
        step("neg256_floor", 0, 1, -256,   1, 0, 0, 0);

        step("to_0_15",      0, 1,   15,   1, 0, 1, 5);
        step("reset_wins",   1, 1,   15,   1, 0, 0, 0);

        count = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
